// File: rtl/twin_stick_mapper.sv
// Twin-stick input conditioner for dual-joystick arcade cores.
// Each player channel turns a left analog stick or a digital pad into a 4-bit run vector, and a
// right analog stick plus the digital aim buttons into a 4-bit aim vector. Both vectors are
// emitted in the cabinet's native bit order. The channel also produces a fire trigger, driven
// either by the digital fire button or by any aim input stretched with a hold timer.
//
// Ports:
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   ce           tick enable for the hold counters only
//   aimfire_en   1: trigger from any aim input (+hold), 0: trigger from digital fire bit
//   joy_dig      per player 32 bits: [3:0] up/down/left/right, [4] fire, [10:7] aim X/B/Y/A
//   joy_la       per player 16 bits left stick, [15:8] Y, [7:0] X, two's complement
//   joy_ra       per player 16 bits right stick, same format
//   btn_run      per player 4-bit run vector, core order
//   btn_aim      per player 4-bit aim vector, core order
//   btn_trigger  per player fire output
module twin_stick_mapper #(
  parameter int unsigned PLAYERS     = 2,
  parameter int unsigned DEADZONE    = 20,
  parameter int unsigned HYST        = 8,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ce,
  input  logic                   aimfire_en,
  input  logic [PLAYERS*32-1:0]  joy_dig,
  input  logic [PLAYERS*16-1:0]  joy_la,
  input  logic [PLAYERS*16-1:0]  joy_ra,
  output logic [PLAYERS*4-1:0]   btn_run,
  output logic [PLAYERS*4-1:0]   btn_aim,
  output logic [PLAYERS-1:0]     btn_trigger
);

  localparam int unsigned CntW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] HoldVal = CntW'(HOLD_CYCLES);

  // Thresholds at 9 bits so that -128 compares correctly without wrapping.
  localparam logic signed [8:0] DzPos  = 9'(DEADZONE);
  localparam logic signed [8:0] DzNeg  = -DzPos;
  localparam logic signed [8:0] RelPos = 9'(DEADZONE - HYST);
  localparam logic signed [8:0] RelNeg = -RelPos;

  // Flags are {up, down, left, right}. A set flag holds until the value falls back inside the
  // release threshold, so opposite flags can never be set together.
  function automatic logic [3:0] next_flags(input logic [3:0] cur, input logic [15:0] v);
    logic signed [8:0] y;
    logic signed [8:0] x;
    logic [3:0]        f;
    y    = $signed({v[15], v[15:8]});
    x    = $signed({v[7], v[7:0]});
    f[3] = cur[3] ? (y < RelNeg) : (y < DzNeg);
    f[2] = cur[2] ? (y > RelPos) : (y > DzPos);
    f[1] = cur[1] ? (x < RelNeg) : (x < DzNeg);
    f[0] = cur[0] ? (x > RelPos) : (x > DzPos);
    return f;
  endfunction

  // Diagonal vector {UR, DL, UL, DR} from {up, down, left, right}.
  function automatic logic [3:0] diag(input logic [3:0] f);
    return {f[3] & f[0], f[2] & f[1], f[3] & f[1], f[2] & f[0]};
  endfunction

  function automatic logic [3:0] core_order(input logic [3:0] d);
    return {d[2], d[0], d[1], d[3]};
  endfunction

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    // Stage 1: hysteresis flags and digital inputs, registered together for alignment.
    logic [3:0]      lf_q, rf_q, drun_q, daim_q;
    logic            fire_q;
    // Stage 2: outputs and hold counter.
    logic [3:0]      run_q, aim_q;
    logic            trig_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      run_d, aim_d;
    logic            any_aim, trig_d;
    logic            unused_dig;

    assign unused_dig = ^{joy_dig[p*32+5 +: 2], joy_dig[p*32+11 +: 21]};

    always_comb begin
      run_d   = (|lf_q) ? diag(lf_q) : drun_q;
      aim_d   = diag(rf_q) | daim_q;
      any_aim = |aim_d;
      cnt_d   = cnt_q;
      if (any_aim) begin
        cnt_d = HoldVal;
      end else if (ce && (cnt_q != '0)) begin
        cnt_d = cnt_q - CntW'(1);
      end
      // The counter runs regardless of source select; only the mux looks at aimfire_en.
      trig_d = aimfire_en ? (any_aim | (cnt_q != '0)) : fire_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        lf_q   <= '0;
        rf_q   <= '0;
        drun_q <= '0;
        daim_q <= '0;
        fire_q <= 1'b0;
        run_q  <= '0;
        aim_q  <= '0;
        trig_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        lf_q   <= next_flags(lf_q, joy_la[p*16 +: 16]);
        rf_q   <= next_flags(rf_q, joy_ra[p*16 +: 16]);
        drun_q <= joy_dig[p*32 +: 4];
        // Aim buttons X, B, Y, A map onto d[3], d[2], d[1], d[0].
        daim_q <= {joy_dig[p*32+7], joy_dig[p*32+8], joy_dig[p*32+9], joy_dig[p*32+10]};
        fire_q <= joy_dig[p*32+4];
        run_q  <= core_order(run_d);
        aim_q  <= core_order(aim_d);
        trig_q <= trig_d;
        cnt_q  <= cnt_d;
      end
    end

    assign btn_run[p*4 +: 4] = run_q;
    assign btn_aim[p*4 +: 4] = aim_q;
    assign btn_trigger[p]    = trig_q;
  end

endmodule

// File: tb/tb_twin_stick_mapper.sv
module tb_twin_stick_mapper;

  localparam int P = 4;

  logic            clk_sys    = 1'b0;
  logic            reset_n    = 1'b0;
  logic            ce         = 1'b0;
  logic            aimfire_en = 1'b0;
  logic [P*32-1:0] joy_dig    = '0;
  logic [P*16-1:0] joy_la     = '0;
  logic [P*16-1:0] joy_ra     = '0;
  logic [P*4-1:0]  btn_run;
  logic [P*4-1:0]  btn_aim;
  logic [P-1:0]    btn_trigger;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  twin_stick_mapper #(
    .PLAYERS     (P),
    .DEADZONE    (20),
    .HYST        (8),
    .HOLD_CYCLES (4)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ce          (ce),
    .aimfire_en  (aimfire_en),
    .joy_dig     (joy_dig),
    .joy_la      (joy_la),
    .joy_ra      (joy_ra),
    .btn_run     (btn_run),
    .btn_aim     (btn_aim),
    .btn_trigger (btn_trigger)
  );

  typedef struct packed {
    logic [15:0] la;
    logic [15:0] ra;
    logic [31:0] dig;
    logic [3:0]  run;
    logic [3:0]  aim;
    logic        trig;
  } vec_t;

  vec_t tbl [18];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_and_reset();
    joy_dig    = '0;
    joy_la     = '0;
    joy_ra     = '0;
    ce         = 1'b0;
    aimfire_en = 1'b0;
    reset_n    = 1'b0;
    step(2);
    reset_n    = 1'b1;
  endtask

  initial begin
    logic [15:0] pat;

    // Left-stick sweeps on P0: {Y, X}. Run outputs in core order {d2, d0, d1, d3}.
    tbl[0]  = '{la: 16'h0000, ra: 16'h0000, dig: 32'h0,   run: 4'b0000, aim: 4'b0000, trig: 1'b0};
    tbl[1]  = '{la: 16'hEB1E, ra: 16'h0000, dig: 32'h0,   run: 4'b0001, aim: 4'b0000, trig: 1'b0};
    tbl[2]  = '{la: 16'hF31E, ra: 16'h0000, dig: 32'h0,   run: 4'b0001, aim: 4'b0000, trig: 1'b0};
    tbl[3]  = '{la: 16'hF41E, ra: 16'h0000, dig: 32'h0,   run: 4'b0000, aim: 4'b0000, trig: 1'b0};
    tbl[4]  = '{la: 16'h001E, ra: 16'h0000, dig: 32'h0,   run: 4'b0000, aim: 4'b0000, trig: 1'b0};
    tbl[5]  = '{la: 16'h801E, ra: 16'h0000, dig: 32'h0,   run: 4'b0001, aim: 4'b0000, trig: 1'b0};
    tbl[6]  = '{la: 16'h7F1E, ra: 16'h0000, dig: 32'h0,   run: 4'b0100, aim: 4'b0000, trig: 1'b0};
    tbl[7]  = '{la: 16'h0000, ra: 16'h0000, dig: 32'h5,   run: 4'b1100, aim: 4'b0000, trig: 1'b0};
    tbl[8]  = '{la: 16'h28D8, ra: 16'h0000, dig: 32'h5,   run: 4'b1000, aim: 4'b0000, trig: 1'b0};
    tbl[9]  = '{la: 16'h0DF3, ra: 16'h0000, dig: 32'h5,   run: 4'b1000, aim: 4'b0000, trig: 1'b0};
    tbl[10] = '{la: 16'h1515, ra: 16'h0000, dig: 32'h5,   run: 4'b0100, aim: 4'b0000, trig: 1'b0};
    tbl[11] = '{la: 16'h8080, ra: 16'h0000, dig: 32'h5,   run: 4'b0010, aim: 4'b0000, trig: 1'b0};
    tbl[12] = '{la: 16'h0000, ra: 16'h0000, dig: 32'hA,   run: 4'b0011, aim: 4'b0000, trig: 1'b0};
    // Aim path, trigger sourced from fire bit (aimfire_en = 0).
    tbl[13] = '{la: 16'h0000, ra: 16'hE2E2, dig: 32'h0,   run: 4'b0000, aim: 4'b0010, trig: 1'b0};
    tbl[14] = '{la: 16'h0000, ra: 16'h0000, dig: 32'h90,  run: 4'b0000, aim: 4'b0001, trig: 1'b1};
    tbl[15] = '{la: 16'h0000, ra: 16'h0000, dig: 32'h500, run: 4'b0000, aim: 4'b1100, trig: 1'b0};
    tbl[16] = '{la: 16'h0000, ra: 16'hE21E, dig: 32'h200, run: 4'b0000, aim: 4'b0011, trig: 1'b0};
    tbl[17] = '{la: 16'h0000, ra: 16'h0000, dig: 32'h0,   run: 4'b0000, aim: 4'b0000, trig: 1'b0};

    // Reset held with every input active: outputs stay 0, then follow 2 cycles after release.
    reset_n    = 1'b0;
    joy_dig    = '1;
    joy_la     = {P{16'h8080}};
    joy_ra     = {P{16'h8080}};
    aimfire_en = 1'b1;
    ce         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("reset_run", 32'(btn_run), 32'h0);
      check("reset_aim", 32'(btn_aim), 32'h0);
      check("reset_trig", 32'(btn_trigger), 32'h0);
    end
    reset_n = 1'b1;
    step(2);
    check("post_reset_run", 32'(btn_run), 32'h2222);
    check("post_reset_aim", 32'(btn_aim), 32'hFFFF);
    check("post_reset_trig", 32'(btn_trigger), 32'hF);
    // Asynchronous reset between clock edges.
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_run", 32'(btn_run), 32'h0);
    check("async_reset_trig", 32'(btn_trigger), 32'h0);

    // Directed table on P0; other channels must stay 0.
    clear_and_reset();
    for (int i = 0; i < 18; i++) begin
      joy_la[15:0]  = tbl[i].la;
      joy_ra[15:0]  = tbl[i].ra;
      joy_dig[31:0] = tbl[i].dig;
      step(2);
      check($sformatf("tbl%0d_run", i), 32'(btn_run), 32'(tbl[i].run));
      check($sformatf("tbl%0d_aim", i), 32'(btn_aim), 32'(tbl[i].aim));
      check($sformatf("tbl%0d_trig", i), 32'(btn_trigger), 32'(tbl[i].trig));
    end

    // One-cycle aim pulse, ce every cycle: trigger high for 1 + 4 cycles.
    clear_and_reset();
    aimfire_en  = 1'b1;
    ce          = 1'b1;
    pat         = '0;
    joy_dig[7]  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 1) joy_dig[7] = 1'b0;
      pat[k] = btn_trigger[0];
    end
    check("hold_ce_every", 32'(pat), 32'h007C);

    // Same pulse, ce every 2nd cycle: trigger high for 1 + 8 cycles.
    clear_and_reset();
    aimfire_en  = 1'b1;
    pat         = '0;
    joy_dig[7]  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      ce = (k % 2 == 0);
      step(1);
      if (k == 1) joy_dig[7] = 1'b0;
      pat[k] = btn_trigger[0];
    end
    check("hold_ce_half", 32'(pat), 32'h07FC);

    // Fire-bit source ignores aim; switching to aim-fire mid-hold shows the remaining count.
    clear_and_reset();
    ce            = 1'b1;
    joy_dig[31:0] = 32'h90;
    step(2);
    check("fire_src_on", 32'(btn_trigger), 32'h1);
    joy_dig[31:0] = 32'h80;
    step(2);
    check("fire_src_aim_only", 32'(btn_trigger), 32'h0);
    joy_dig[31:0] = 32'h0;
    step(2);
    check("fire_src_released", 32'(btn_trigger), 32'h0);
    aimfire_en = 1'b1;
    pat        = '0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      pat[k] = btn_trigger[0];
    end
    check("switch_mid_hold", 32'(pat), 32'h0007);

    // Four players with distinct patterns: no cross-talk.
    clear_and_reset();
    joy_dig = {32'h0, 32'h100, 32'h10, 32'h1};
    joy_la  = {16'h0000, 16'h0000, 16'hEB1E, 16'h0000};
    joy_ra  = {16'hCECE, 16'h0000, 16'h0000, 16'h0000};
    step(2);
    check("multi_run", 32'(btn_run), 32'h0014);
    check("multi_aim", 32'(btn_aim), 32'h2800);
    check("multi_trig", 32'(btn_trigger), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
